// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, oversampling ratio, transmitter
// state type and a frame-length helper used by benches and the future receiver.
package uart_pkg;

  localparam int unsigned UART_PARITY_NONE = 0;
  localparam int unsigned UART_PARITY_ODD  = 1;
  localparam int unsigned UART_PARITY_EVEN = 2;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned PHASE_W    = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Clock cycles of one complete frame at the 16x baud clock.
  function automatic int unsigned frame_cycles(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
    int unsigned par_bits;
    par_bits = (parity != UART_PARITY_NONE) ? 1 : 0;
    return OVERSAMPLE * (1 + data_bits + par_bits + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side bus of the parametrised UART transmitter: character queueing
// handshake, FIFO status and the serial line.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);

  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] trans_data;
  logic                 trans_write;
  logic                 trans_busy;
  logic                 trans_idle;
  logic [LEVEL_W-1:0]   trans_level;
  logic                 tx;

  modport master (
    output trans_data,
    output trans_write,
    input  trans_busy,
    input  trans_idle,
    input  trans_level,
    input  tx
  );

  modport slave (
    input  trans_data,
    input  trans_write,
    output trans_busy,
    output trans_idle,
    output trans_level,
    output tx
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy; DEPTH must be a
// power of two so the pointers wrap without extra logic.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push;
  logic             pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  // A write while full is dropped even if a read frees a slot this cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: queues characters in a small FIFO and shifts
// them out back-to-back as start / data (LSB first) / optional parity / stop.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = UART_PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_baud_16x,
  input  logic             reset,
  uart_tx_param_if.slave   bus
);

  localparam int unsigned BIDX_W     = $clog2(DATA_BITS);
  localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam bit          HAS_PARITY = (PARITY != UART_PARITY_NONE);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY > UART_PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two in 2..256");
  end

  tx_state_e             state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;

  logic                  bit_end;
  logic                  start_frame;
  logic                  fifo_pop;
  logic [DATA_BITS-1:0]  fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LEVEL_W-1:0]    fifo_level;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_baud_16x),
    .rst_n   (reset),
    .wr_en   (bus.trans_write),
    .wr_data (bus.trans_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bit_end = (phase_q == '1);

  // Next-state logic; tx_d always carries the line level of the bit being entered.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + PHASE_W'(1);
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        phase_d     = '0;
        tx_d        = 1'b1;
        start_frame = !fifo_empty;
      end
      TX_START: begin
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == BIDX_W'(DATA_BITS - 1)) begin
            if (HAS_PARITY) begin
              state_d = TX_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = TX_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIDX_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_d    = TX_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = TX_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Pop and latch the character so later FIFO writes cannot disturb this frame.
    if (start_frame) begin
      fifo_pop = 1'b1;
      state_d  = TX_START;
      phase_d  = '0;
      shift_d  = fifo_rd_data;
      parity_d = (PARITY == UART_PARITY_ODD) ? ~(^fifo_rd_data) : (^fifo_rd_data);
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_baud_16x) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      phase_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.trans_busy  = fifo_full;
  assign bus.trans_idle  = (state_q == TX_IDLE) && fifo_empty;
  assign bus.trans_level = fifo_level;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboarded bench for uart_tx_param: three configurations share one stimulus
// stream; a cycle-level queue model predicts pops, and line monitors decode frames.
module tb_uart_tx_param;

  localparam int unsigned NCFG = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req;
  logic [8:0]  wr_val;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int unsigned exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned DB    = (g == 0) ? 8 : (g == 1) ? 7 : 9;
    localparam int unsigned PAR   = (g == 0) ? 0 : (g == 1) ? 2 : 1;
    localparam int unsigned SB    = (g == 1) ? 2 : 1;
    localparam int unsigned DEPTH = (g == 2) ? 2 : 4;
    localparam int unsigned NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int unsigned FRAME = 16 * NBITS;

    uart_tx_param_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_param #(
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (DEPTH)
    ) dut (
      .clk_baud_16x (clk),
      .reset        (rst_n),
      .bus          (bus)
    );

    assign bus.trans_write = wr_req;
    assign bus.trans_data  = wr_val[DB-1:0];

    int unsigned fifo_m[$];
    int unsigned exp_ch[$];
    int unsigned exp_t[$];
    int unsigned busy_until = 0;
    int unsigned epoch = 0;
    bit          quiet = 1'b0;

    // Reference: queue of accepted characters; the line takes one whenever it is free.
    always @(posedge clk) begin
      int unsigned e;
      bit          pop;
      e = cyc + 1;
      if (!rst_n) begin
        fifo_m.delete();
        exp_ch.delete();
        exp_t.delete();
        busy_until = 0;
        epoch++;
      end else begin
        pop = (fifo_m.size() > 0) && (e >= busy_until);
        if (wr_req && fifo_m.size() < DEPTH)
          fifo_m.push_back(32'(wr_val) & ((32'd1 << DB) - 1));
        if (pop) begin
          exp_ch.push_back(fifo_m.pop_front());
          exp_t.push_back(e);
          busy_until = e + FRAME;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("cfg%0d trans_level", g), 32'(bus.trans_level), fifo_m.size());
      check($sformatf("cfg%0d trans_busy", g), 32'(bus.trans_busy),
            (fifo_m.size() == DEPTH) ? 1 : 0);
      check($sformatf("cfg%0d trans_idle", g), 32'(bus.trans_idle),
            (fifo_m.size() == 0 && cyc >= busy_until) ? 1 : 0);
      if (cyc >= busy_until)
        check($sformatf("cfg%0d tx idle high", g), 32'(bus.tx), 1);
      quiet <= (fifo_m.size() == 0) && (cyc >= busy_until + 2);
    end

    int unsigned t0, ch, et, ep, d;
    logic [15:0] bits, fr;

    // Line monitor: find a start bit, sample every bit mid-way, score the frame.
    initial begin : mon
      forever begin
        @(negedge clk);
        if (bus.tx === 1'b0) begin
          t0 = cyc;
          ep = epoch;
          if (exp_ch.size() == 0) begin
            check($sformatf("cfg%0d start with nothing queued", g), 32'(bus.tx), 1);
            while (cyc < t0 + FRAME - 1 && epoch == ep) @(negedge clk);
          end else begin
            ch   = exp_ch.pop_front();
            et   = exp_t.pop_front();
            bits = '0;
            check($sformatf("cfg%0d start cycle", g), t0, et);
            for (int i = 0; i < int'(NBITS); i++) begin
              while (cyc < t0 + 16 * i + 8 && epoch == ep) @(negedge clk);
              if (epoch != ep) break;
              bits[i] = bus.tx;
            end
            if (epoch == ep) begin
              fr = 16'(ch << 1);
              if (PAR != 0)
                fr[1 + DB] = 1'(($countones(ch) & 1) ^ ((PAR == 1) ? 1 : 0));
              for (int s = 0; s < int'(SB); s++) fr[NBITS - 1 - s] = 1'b1;
              d = 0;
              for (int i = 0; i < int'(DB); i++) d = d | (32'(bits[1 + i]) << i);
              check($sformatf("cfg%0d data", g), d, ch);
              check($sformatf("cfg%0d frame bits", g), 32'(bits), 32'(fr));
              while (cyc < t0 + FRAME - 1 && epoch == ep) @(negedge clk);
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_one(input int unsigned v);
    wr_req = 1'b1;
    wr_val = 9'(v);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  initial begin
    int rate;
    rst_n  = 1'b0;
    wr_req = 1'b0;
    wr_val = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    write_one(32'h055);
    idle(260);
    write_one(32'h041);
    idle(260);
    write_one(32'h0A3);
    write_one(32'h00F);
    idle(500);

    // Write strobe held for six cycles: excess characters must be dropped.
    for (int i = 1; i <= 6; i++) begin
      wr_req = 1'b1;
      wr_val = 9'(i);
      @(negedge clk);
    end
    wr_req = 1'b0;
    idle(1500);

    // Reset lands inside data bit 3 of the first frame with two characters queued.
    write_one(32'h1C5);
    write_one(32'h0B2);
    write_one(32'h13C);
    idle(68);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(400);

    rate = 20;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) rate = int'($urandom_range(2, 60));
      wr_req = ($urandom_range(0, 99) < rate);
      wr_val = 9'($urandom);
      @(negedge clk);
    end

    // Saturated writes exercise write-at-full coinciding with a pop.
    for (int n = 0; n < 400; n++) begin
      wr_req = 1'b1;
      wr_val = 9'($urandom);
      @(negedge clk);
    end
    wr_req = 1'b0;

    for (int n = 0; n < 6000; n++) begin
      if (g_cfg[0].quiet && g_cfg[1].quiet && g_cfg[2].quiet) break;
      @(negedge clk);
    end
    check("drain all configs quiet",
          32'({g_cfg[2].quiet, g_cfg[1].quiet, g_cfg[0].quiet}), 7);
    check("cfg0 frames never seen", g_cfg[0].exp_ch.size(), 0);
    check("cfg1 frames never seen", g_cfg[1].exp_ch.size(), 0);
    check("cfg2 frames never seen", g_cfg[2].exp_ch.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. It adds configurable data width, parity and stop bits, plus a small transmit FIFO so software/producers can queue characters. Frames are emitted back-to-back with no idle gap. It runs from the 16x baud clock and sits between a bus/register bridge and the tx pin.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even; other values are illegal (elaboration error)
STOP_BITS, 1, stop bits per frame, legal 1 or 2
FIFO_DEPTH, 4, transmit FIFO entries, power of two, 2..256

Ports:
clk_baud_16x  in   1  16x baud clock; single clock domain
reset  in   1  synchronous, active-low (0 = reset on rising edge of clk_baud_16x)
trans_data  in   DATA_BITS  character to queue
trans_write  in   1  write strobe; accepted when trans_busy = 0
trans_busy  out  1  FIFO full; writes ignored while high
trans_idle  out  1  FIFO empty and shifter idle (line quiescent)
trans_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
tx  out  1  serial line, idle high

Behaviour:
- Reset (reset = 0 at an edge): FIFO empty, trans_level = 0, trans_busy = 0, trans_idle = 1, tx = 1, FSM = IDLE. Reset overrides everything, including mid-frame; tx returns high the cycle after.
- Bit time: 16 clk_baud_16x cycles, counted by a 4-bit phase counter. The counter is cleared on frame start.
- Frame: start (0), DATA_BITS data bits LSB first, optional parity, then STOP_BITS stop bits (1).
  - Even parity: XOR of the data bits.
  - Odd parity: its inverse.
- FSM states: IDLE -> START -> DATA -> [PARITY if PARITY != 0] -> STOP -> IDLE or START.
  - DATA uses a bit index 0..DATA_BITS-1.
  - STOP lasts STOP_BITS*16 cycles.
- Pop rule:
  - In IDLE with FIFO non-empty, pop at the next edge and enter START; tx = 0 from that edge.
  - At the final cycle of STOP with FIFO non-empty, pop and enter START directly. There is no idle gap.
  - Otherwise go to IDLE.
- Latency: a write accepted at edge k into an empty FIFO with the FSM in IDLE causes tx to fall at edge k+1.
- Frame length: 16*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles. For 8N1 this is 160.
- Write acceptance: trans_write && !trans_busy, sampled at the edge. trans_busy = (trans_level == FIFO_DEPTH), combinational from registers.
  - When full, a write is dropped even if a pop occurs in the same cycle.
  - Simultaneous write and pop on a non-full FIFO leaves trans_level unchanged.
- The character is captured into the shift register at pop. FIFO contents after pop do not affect the frame in flight.
- trans_idle = (FSM == IDLE) && (trans_level == 0). It is 0 throughout every frame, including the stop bits.
- Pointers wrap modulo FIFO_DEPTH. trans_level saturates naturally because no write is accepted at full.
- tx is registered: no combinational path from inputs.

Decomposition:
- Package uart_pkg: parity encodings (UART_PARITY_NONE/ODD/EVEN), OVERSAMPLE = 16, and a frame-length function for the bench.
- Sub-module uart_sync_fifo (single-clock, parametrised WIDTH/DEPTH, full/empty/level outputs), reused later by the receiver.
- FSM and shifter live in uart_tx_param.

Test Plan:
- 8N1, write 0x55 once -> tx low 16 cycles, then 1,0,1,0,1,0,1,0 per 16 cycles, then high. trans_idle returns 1 exactly 160 cycles after tx falls.
- DATA_BITS=7, PARITY=2, write 0x41 -> parity bit 0, frame 160 cycles. With PARITY=1 -> parity bit 1.
- STOP_BITS=2, two back-to-back writes 0xA3, 0x0F -> second start bit begins exactly 32 cycles after the first frame's first stop bit, with no extra idle.
- FIFO_DEPTH=4, trans_write held high for 6 consecutive cycles from idle, data 1..6 -> first 5 accepted, then trans_busy = 1 and the 6th dropped. tx emits 1,2,3,4,5 contiguously, then trans_level = 0 and trans_idle = 1.
- Reset pulsed low mid data bit 3 of a frame, with 2 entries queued -> next cycle tx = 1, trans_level = 0, trans_idle = 1, and no further frames.
- Write at full while a pop occurs in the same cycle -> write dropped and trans_level decrements by 1.
